// File: rtl/t_ramp_gen.sv
// Temperature trajectory generator: integrates a 2^-k scaled Q7.0 slope into a
// clamped Q7.7 accumulator and emits Q7.0 samples at a programmable rate.
module t_ramp_gen #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init,
    input  logic             run,
    input  logic [7:0]       T_start,
    input  logic [7:0]       dT_cmd,
    input  logic [7:0]       k_dt,
    input  logic [7:0]       t_lo,
    input  logic [7:0]       t_hi,
    input  logic [CNT_W-1:0] period,
    output logic [7:0]       T_out,
    output logic             t_valid,
    output logic             sat
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SAT  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic signed [15:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         t_out_q, t_out_d;
    logic               t_valid_q, t_valid_d;
    logic               sat_q, sat_d;

    logic [3:0]         k_eff_s;
    logic signed [15:0] step_base_s;
    logic signed [15:0] step_s;
    logic signed [16:0] sum_s;
    logic signed [16:0] acc_new_s;
    logic signed [16:0] start_s;
    logic signed [16:0] start_clamp_s;
    logic               bounds_bad_s;
    logic               clamped_s;
    logic               start_clamped_s;
    logic               tick_s;

    function automatic logic signed [16:0] to_q77(input logic [7:0] t);
        return {{2{t[7]}}, t, 7'd0};
    endfunction

    // Upper bound applied last so inverted bounds collapse onto t_hi.
    function automatic logic signed [16:0] clamp_q77(input logic signed [16:0] v,
                                                     input logic [7:0] lo,
                                                     input logic [7:0] hi);
        logic signed [16:0] lo7;
        logic signed [16:0] hi7;
        logic signed [16:0] r;
        lo7 = to_q77(lo);
        hi7 = to_q77(hi);
        r   = (v < lo7) ? lo7 : v;
        r   = (r > hi7) ? hi7 : r;
        return r;
    endfunction

    // Q7.7 -> Q7.0 toward zero: bias negatives by 127 before the arithmetic shift.
    function automatic logic [7:0] trunc0(input logic signed [15:0] a);
        logic signed [15:0] b;
        b = a[15] ? (a + 16'sd127) : a;
        return 8'(b >>> 7);
    endfunction

    // Slope scaling, accumulation and clamping of both the running sum and T_start.
    always_comb begin
        k_eff_s         = (k_dt > 8'd15) ? 4'd15 : k_dt[3:0];
        step_base_s     = {dT_cmd[7], dT_cmd, 7'd0};
        step_s          = step_base_s >>> k_eff_s;
        sum_s           = {acc_q[15], acc_q} + {step_s[15], step_s};
        bounds_bad_s    = ($signed(t_lo) > $signed(t_hi));
        acc_new_s       = clamp_q77(sum_s, t_lo, t_hi);
        clamped_s       = (acc_new_s != sum_s) || bounds_bad_s;
        start_s         = to_q77(T_start);
        start_clamp_s   = clamp_q77(start_s, t_lo, t_hi);
        start_clamped_s = (start_clamp_s != start_s) || bounds_bad_s;
    end

    // Next-state logic: init overrides everything, then run level, then tick.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        t_out_d   = t_out_q;
        t_valid_d = 1'b0;
        sat_d     = sat_q;
        tick_s    = 1'b0;
        if (init) begin
            acc_d   = 16'(start_clamp_s);
            t_out_d = trunc0(16'(start_clamp_s));
            cnt_d   = {CNT_W{1'b0}};
            sat_d   = start_clamped_s;
            if (run) begin
                state_d = start_clamped_s ? ST_SAT : ST_RUN;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d   = {CNT_W{1'b0}};
                    sat_d   = 1'b0;
                    state_d = run ? ST_RUN : ST_IDLE;
                end
                ST_RUN, ST_SAT: begin
                    if (!run) begin
                        state_d = ST_IDLE;
                        cnt_d   = {CNT_W{1'b0}};
                        sat_d   = 1'b0;
                    end else if (cnt_q == period) begin
                        tick_s    = 1'b1;
                        cnt_d     = {CNT_W{1'b0}};
                        acc_d     = 16'(acc_new_s);
                        t_out_d   = trunc0(16'(acc_new_s));
                        t_valid_d = 1'b1;
                        state_d   = clamped_s ? ST_SAT : ST_RUN;
                        sat_d     = clamped_s;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        sat_d = (state_q == ST_SAT);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                    sat_d   = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= 16'sd0;
            cnt_q     <= {CNT_W{1'b0}};
            t_out_q   <= 8'd0;
            t_valid_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            t_out_q   <= t_out_d;
            t_valid_q <= t_valid_d;
            sat_q     <= sat_d;
        end
    end

    assign T_out   = t_out_q;
    assign t_valid = t_valid_q;
    assign sat     = sat_q;

endmodule

// File: tb/tb_t_ramp_gen.sv
// Scoreboard bench for t_ramp_gen: integer reference model predicts strobes and
// levels; a negedge monitor pops expected samples whenever t_valid is seen.
module tb_t_ramp_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       init;
    logic       run;
    logic [7:0] T_start;
    logic [7:0] dT_cmd;
    logic [7:0] k_dt;
    logic [7:0] t_lo;
    logic [7:0] t_hi;
    logic [7:0] period;
    logic [7:0] T_out;
    logic       t_valid;
    logic       sat;

    always #5 clk = ~clk;

    t_ramp_gen #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .init(init), .run(run),
        .T_start(T_start), .dT_cmd(dT_cmd), .k_dt(k_dt),
        .t_lo(t_lo), .t_hi(t_hi), .period(period),
        .T_out(T_out), .t_valid(t_valid), .sat(sat)
    );

    typedef struct {
        int cyc;
        int tout;
        bit sat;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    // Reference model state (acc in units of 1/128 degree).
    int m_acc, m_cnt, m_tout;
    bit m_running, m_sat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int sx(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    function automatic int clamp_m(input int v, output bit c);
        int lo, hi, r;
        lo = sx(t_lo) * 128;
        hi = sx(t_hi) * 128;
        r  = v;
        if (r < lo) r = lo;
        if (r > hi) r = hi;
        c  = (r != v) || (sx(t_lo) > sx(t_hi));
        return r;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_cnt = 0; m_tout = 0; m_running = 0; m_sat = 0;
    endtask

    // Predict the effect of the coming clock edge from the inputs now applied.
    task automatic model_step();
        bit   c;
        int   k, step;
        exp_t e;
        if (!rst_n) begin
            model_reset();
        end else if (init) begin
            m_acc     = clamp_m(sx(T_start) * 128, c);
            m_tout    = m_acc / 128;
            m_sat     = c;
            m_running = run;
            m_cnt     = 0;
        end else if (!m_running) begin
            m_cnt = 0;
            m_sat = 0;
            if (run) m_running = 1;
        end else if (!run) begin
            m_running = 0;
            m_cnt     = 0;
            m_sat     = 0;
        end else if (m_cnt == int'(period)) begin
            k      = (int'(k_dt) > 15) ? 15 : int'(k_dt);
            step   = (sx(dT_cmd) * 128) >>> k;
            m_acc  = clamp_m(m_acc + step, c);
            m_tout = m_acc / 128;
            m_sat  = c;
            m_cnt  = 0;
            e.cyc  = cyc + 1;
            e.tout = m_tout;
            e.sat  = c;
            q.push_back(e);
        end else begin
            m_cnt = (m_cnt + 1) % 256;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #2;
        chk("level_T_out", sx(T_out), m_tout);
        chk("level_sat", int'(sat), int'(m_sat));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_init(input int ts);
        T_start = 8'(ts);
        init    = 1'b1;
        tick();
        init    = 1'b0;
    endtask

    // Monitor: compare every strobe against the oldest expected sample.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_strobe at cycle %0d: t_valid=0 expected strobe T_out=%0d", e.cyc, e.tout);
            end
            if (t_valid) begin
                if (q.size() > 0 && q[0].cyc == cyc) begin
                    e = q.pop_front();
                    chk("strobe_T_out", sx(T_out), e.tout);
                    chk("strobe_sat", int'(sat), int'(e.sat));
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe at cycle %0d: t_valid=1 expected 0", cyc);
                end
            end
        end
    end

    initial begin
        int tmp;
        rst_n = 1'b0; init = 1'b0; run = 1'b0;
        T_start = 8'd0; dT_cmd = 8'd0; k_dt = 8'd0;
        t_lo = 8'(-100); t_hi = 8'd100; period = 8'd0;
        model_reset();
        ticks(2);
        chk("reset_t_valid", int'(t_valid), 0);
        rst_n = 1'b1;
        ticks(2);

        // Basic ramp with period 3.
        dT_cmd = 8'd3; k_dt = 8'd0; period = 8'd3; run = 1'b1;
        do_init(10);
        chk("init_no_strobe", int'(t_valid), 0);
        ticks(13);

        // Fractional slope.
        dT_cmd = 8'd1; k_dt = 8'd2; period = 8'd0;
        do_init(10);
        ticks(6);

        // Negative truncation toward zero.
        dT_cmd = 8'(-1); k_dt = 8'd1;
        do_init(0);
        ticks(4);

        // Saturation at upper bound, release, then inverted bounds.
        dT_cmd = 8'd4; k_dt = 8'd0;
        do_init(95);
        ticks(3);
        dT_cmd = 8'(-4);
        ticks(2);
        t_lo = 8'd50; t_hi = 8'd40;
        ticks(2);
        chk("inverted_bounds_T_out", sx(T_out), 40);
        t_lo = 8'(-100); t_hi = 8'd100;

        // init coinciding with a tick, then run dropped mid-period.
        dT_cmd = 8'd2; period = 8'd2;
        do_init(5);
        ticks(2);
        do_init(20);
        ticks(1);
        run = 1'b0;
        ticks(2);
        run = 1'b1;
        ticks(8);

        // Asynchronous reset during an active ramp.
        period = 8'd0;
        ticks(3);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_T_out", sx(T_out), 0);
        chk("async_rst_t_valid", int'(t_valid), 0);
        chk("async_rst_sat", int'(sat), 0);
        model_reset();
        ticks(2);
        rst_n = 1'b1;
        period = 8'd2;
        ticks(8);

        // Randomized phase.
        for (int i = 0; i < 2500; i++) begin
            init = ($urandom_range(0, 19) == 0);
            if (init) T_start = 8'($urandom);
            if ($urandom_range(0, 29) == 0) run = ~run;
            if ($urandom_range(0, 39) == 0) period = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 9) == 0) begin
                dT_cmd = 8'($urandom);
                k_dt   = 8'($urandom_range(0, 20));
            end
            if ($urandom_range(0, 49) == 0) begin
                tmp  = $urandom_range(0, 128);
                t_lo = 8'(-tmp);
                t_hi = 8'($urandom_range(0, 127));
                if ($urandom_range(0, 9) == 0) begin
                    t_lo = 8'($urandom_range(20, 100));
                    t_hi = 8'($urandom_range(0, 19));
                end
            end
            tick();
        end
        init = 1'b0;
        run  = 1'b0;
        ticks(3);
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
